dmem_access_ctrl: RTL and testbench

Sequencer and arbiter that shares one byte-wide, single-ported data memory between the instruction-fetch path and the load/store path of the 64-bit core. Each port issues one request at a time. The block grants requests round-robin, performs the access one byte per cycle in little-endian order, assembles and sign/zero-extends load data, and returns it with a one-cycle acknowledge. It sits between the core's IF/MEM stages and the 512-byte byte-array memory.

---
 rtl/dmem_access_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: round-robin sequencer sharing a byte-wide memory between fetch and load/store,
// one byte per cycle, little-endian, with load extension and a one-cycle acknowledge.
module dmem_access_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [63:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_ack,
    output logic [63:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              r_state;
    logic                r_port;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [63:0]         r_wdata;
    logic [63:0]         r_acc;
    logic [1:0]          r_size;
    logic                r_we;
    logic                r_uns;
    logic [2:0]          r_idx;
    logic                r_if_ack;
    logic                r_d_ack;
    logic [31:0]         r_if_rdata;
    logic [63:0]         r_d_rdata;

    logic                w_grant_d;
    logic [3:0]          w_n;
    logic                w_last;
    logic [63:0]         w_acc_nxt;
    logic [63:0]         w_ext;
    logic [7:0]          w_wbyte;
    logic                w_sgn;
    logic                w_unused;

    // Tie goes to the port not served last; r_last = 1 means data was last.
    assign w_grant_d = d_req & (~if_req | ~r_last);
    assign w_n       = 4'd1 << r_size;
    assign w_last    = {1'b0, r_idx} == w_n - 4'd1;
    assign w_acc_nxt = r_acc | ({56'b0, mem_rdata} << {r_idx, 3'b000});
    assign w_wbyte   = 8'(r_wdata >> {r_idx, 3'b000});
    assign w_sgn     = ~r_uns;
    assign w_ext     = r_size == 2'd0 ? {{56{w_sgn & w_acc_nxt[7]}},  w_acc_nxt[7:0]}  :
                       r_size == 2'd1 ? {{48{w_sgn & w_acc_nxt[15]}}, w_acc_nxt[15:0]} :
                       r_size == 2'd2 ? {{32{w_sgn & w_acc_nxt[31]}}, w_acc_nxt[31:0]} :
                       w_acc_nxt;
    assign w_unused  = ^{if_addr[63:ADDR_W], d_addr[63:ADDR_W]};

    // The write is suppressed while reset is high so an aborted store stops on that cycle.
    assign mem_addr  = r_state == XFER ? r_addr + ADDR_W'(r_idx) : '0;
    assign mem_we    = r_state == XFER && r_we && !reset;
    assign mem_wdata = mem_we ? w_wbyte : 8'd0;
    assign busy      = r_state != IDLE;
    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_port     <= 1'b0;
            r_last     <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_acc      <= '0;
            r_size     <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_idx      <= '0;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                IDLE: if (if_req || d_req) begin
                    r_port  <= w_grant_d;
                    r_last  <= w_grant_d;
                    r_addr  <= w_grant_d ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                    r_size  <= w_grant_d ? d_size : 2'd2;
                    r_we    <= w_grant_d & d_we;
                    r_uns   <= d_unsigned;
                    r_wdata <= d_wdata;
                    r_idx   <= '0;
                    r_acc   <= '0;
                    r_state <= XFER;
                end
                XFER: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + 3'd1;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_if_ack <= ~r_port;
                        r_d_ack  <= r_port;
                        if (!r_port) r_if_rdata <= w_acc_nxt[31:0];
                        else if (!r_we) r_d_rdata <= w_ext;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed vectors with hand-computed expectations against a behavioural byte memory.
module tb_dmem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic        d_unsigned = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  mem [512];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          both_ack = 1'b0;
    bit          fetch_we = 1'b0;

    dmem_access_ctrl #(.ADDR_W(9)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = mem[mem_addr];

    always @(negedge clk) begin
        if (if_ack && d_ack) both_ack = 1'b1;
        if (if_req && mem_we) fetch_we = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd8(input int a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = mem[(a + k) % 512];
        return r;
    endfunction

    task automatic data_op(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [63:0] a, input logic [63:0] wd, output int lat);
        int t0;
        d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd; d_req = 1'b1;
        t0 = cyc;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (d_ack) lat = cyc - t0;
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic fetch_op(input logic [63:0] a, output int lat);
        int t0;
        if_addr = a; if_req = 1'b1;
        t0 = cyc;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (if_ack) lat = cyc - t0;
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        int lat;
        int t0;
        int na;
        int offs [4];
        bit isd [4];
        bit seen;
        for (int k = 0; k < 512; k++) mem[k] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]} = 32'h00A00513;
        {mem[19], mem[18], mem[17], mem[16]} = 32'h0BADC0DE;
        for (int k = 64; k < 72; k++) mem[k] = 8'hEE;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        check("rst_mem", {45'd0, mem_addr, mem_we, mem_wdata}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Tie right after reset: fetch, data, fetch, data.
        if_addr = 64'd0;
        d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b1; d_addr = 64'd16;
        if_req = 1'b1; d_req = 1'b1;
        t0 = cyc; na = 0;
        for (int k = 0; k < 4; k++) begin offs[k] = -1; isd[k] = 1'b0; end
        for (int k = 0; k < 40 && na < 4; k++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                offs[na] = cyc - t0;
                isd[na] = d_ack;
                na++;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        check("tie_count", 64'(na), 64'd4);
        check("tie_off0", 64'(offs[0]), 64'd5);
        check("tie_off1", 64'(offs[1]), 64'd11);
        check("tie_off2", 64'(offs[2]), 64'd17);
        check("tie_off3", 64'(offs[3]), 64'd23);
        check("tie_order", {60'd0, isd[0], isd[1], isd[2], isd[3]}, 64'b0101);
        check("tie_if_rdata", 64'(if_rdata), 64'h00A00513);
        check("tie_d_rdata", d_rdata, 64'h0BADC0DE);

        data_op(1'b1, 2'd3, 1'b0, 64'd16, 64'h1122334455667788, lat);
        check("sd_lat", 64'(lat), 64'd9);
        check("sd_mem", rd8(16), 64'h1122334455667788);
        data_op(1'b0, 2'd3, 1'b1, 64'd16, 64'd0, lat);
        check("ld_lat", 64'(lat), 64'd9);
        check("ld_data", d_rdata, 64'h1122334455667788);

        data_op(1'b1, 2'd0, 1'b0, 64'd40, 64'hDEADBEEFCAFE0088, lat);
        check("sb_lat", 64'(lat), 64'd2);
        check("sb_mem", {48'd0, mem[41], mem[40]}, 64'h0088);
        data_op(1'b0, 2'd0, 1'b0, 64'd40, 64'd0, lat);
        check("lb_signed", d_rdata, 64'hFFFFFFFFFFFFFF88);
        data_op(1'b0, 2'd0, 1'b1, 64'd40, 64'd0, lat);
        check("lbu", d_rdata, 64'h0000000000000088);
        data_op(1'b1, 2'd1, 1'b0, 64'd42, 64'h0000000000007FFF, lat);
        check("sh_lat", 64'(lat), 64'd3);
        data_op(1'b0, 2'd1, 1'b0, 64'd42, 64'd0, lat);
        check("lh_pos", d_rdata, 64'h0000000000007FFF);
        data_op(1'b1, 2'd2, 1'b0, 64'd48, 64'h00000000CAFEF00D, lat);
        check("sw_unchanged_rdata", d_rdata, 64'h0000000000007FFF);

        fetch_op(64'd0, lat);
        check("if_lat", 64'(lat), 64'd5);
        check("if_rdata", 64'(if_rdata), 64'h00A00513);
        check("if_no_we", 64'(fetch_we), 64'd0);

        data_op(1'b1, 2'd1, 1'b0, 64'd511, 64'h000000000000ABCD, lat);
        check("wrap_mem", {48'd0, mem[0], mem[511]}, 64'hABCD);
        data_op(1'b0, 2'd1, 1'b0, 64'd511, 64'd0, lat);
        check("wrap_lh", d_rdata, 64'hFFFFFFFFFFFFABCD);

        // Abort a double store in its 4th transfer cycle.
        d_we = 1'b1; d_size = 2'd3; d_unsigned = 1'b0; d_addr = 64'd64;
        d_wdata = 64'h0807060504030201; d_req = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= d_ack;
            @(posedge clk); #1;
        end
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        seen |= d_ack;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_acks", {62'd0, if_ack, d_ack}, 64'd0);
        check("abort_rdata", {if_rdata, d_rdata[31:0]} | {32'd0, d_rdata[63:32]}, 64'd0);
        check("abort_mem_if", {45'd0, mem_addr, mem_we, mem_wdata}, 64'd0);
        repeat (10) begin
            @(negedge clk);
            seen |= d_ack;
        end
        check("abort_no_ack", 64'(seen), 64'd0);
        check("abort_mem", rd8(64), 64'hEEEEEEEEEE030201);
        check("never_both_ack", 64'(both_ack), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
